// File: rtl/ws2812_rx_if.sv
// WS2812 receiver signal bundle: serial pins plus the decoded-word outputs.
interface ws2812_rx_if;
  logic       din;
  logic       dout;
  logic       valid;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       latch;
  logic       error;
  logic       receiving;

  modport master (output din, input dout, valid, red, green, blue, latch, error, receiving);
  modport slave  (input din, output dout, valid, red, green, blue, latch, error, receiving);
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 receiver: decodes the first GRB word of a frame, forwards the rest of
// the frame on dout, and flags latch gaps and timing violations.
module ws2812_rx #(
  parameter int BIT_THRESHOLD = 52,
  parameter int MIN_HIGH      = 8,
  parameter int MAX_HIGH      = 129,
  parameter int RESET_CYCLES  = 4296
) (
  input  logic       clk,
  input  logic       reset,
  ws2812_rx_if.slave bus
);
  localparam logic [2:0] S_WAIT_GAP = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_HIGH     = 3'd2;
  localparam logic [2:0] S_LOW      = 3'd3;
  localparam logic [2:0] S_FWD      = 3'd4;

  // counter_q is zero in the cycle after an edge, so a level that has lasted
  // N cycles (edge cycle included) shows counter_q == N-1.
  localparam logic [15:0] C_ONE = 16'(BIT_THRESHOLD - 1);
  localparam logic [15:0] C_MIN = 16'(MIN_HIGH - 1);
  localparam logic [15:0] C_MAX = 16'(MAX_HIGH);
  localparam logic [15:0] C_GAP = 16'(RESET_CYCLES - 1);

  logic        din_meta_q, din_meta_d;
  logic        din_s_q, din_s_d;
  logic        din_d_q, din_d_d;
  logic [2:0]  state_q, state_d;
  logic [15:0] counter_q, counter_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [22:0] shift_q, shift_d;
  logic [7:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic        valid_q, valid_d, latch_q, latch_d, error_q, error_d;
  logic        rise, fall, bit_val, low_gap;
  logic [23:0] word;

  assign rise    = din_s_q & ~din_d_q;
  assign fall    = ~din_s_q & din_d_q;
  assign bit_val = (counter_q >= C_ONE);
  assign low_gap = ~din_s_q & ~fall & (counter_q >= C_GAP);
  // The 24th bit goes straight to the outputs, so only 23 bits are stored.
  assign word    = {shift_q, bit_val};

  always_comb begin
    din_meta_d = bus.din;
    din_s_d    = din_meta_q;
    din_d_d    = din_s_q;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    red_d      = red_q;
    green_d    = green_q;
    blue_d     = blue_q;
    valid_d    = 1'b0;
    latch_d    = 1'b0;
    error_d    = 1'b0;

    if (rise || fall)             counter_d = '0;
    else if (counter_q != 16'hFFFF) counter_d = counter_q + 16'd1;
    else                          counter_d = counter_q;

    case (state_q)
      S_WAIT_GAP: begin
        bit_cnt_d = '0;
        // Only continuous low time counts towards the gap.
        if (din_s_q)                 counter_d = '0;
        else if (counter_q >= C_GAP) state_d = S_IDLE;
      end
      S_IDLE: if (rise) state_d = S_HIGH;
      S_HIGH: begin
        if (fall) begin
          if (counter_q < C_MIN) begin
            error_d   = 1'b1;
            bit_cnt_d = '0;
            state_d   = S_WAIT_GAP;
          end else if (bit_cnt_q == 5'd23) begin
            green_d   = word[23:16];
            red_d     = word[15:8];
            blue_d    = word[7:0];
            valid_d   = 1'b1;
            bit_cnt_d = 5'd24;
            state_d   = S_FWD;
          end else begin
            shift_d   = {shift_q[21:0], bit_val};
            bit_cnt_d = bit_cnt_q + 5'd1;
            state_d   = S_LOW;
          end
        end else if (counter_q >= C_MAX) begin
          error_d   = 1'b1;
          bit_cnt_d = '0;
          state_d   = S_WAIT_GAP;
        end
      end
      S_LOW: begin
        if (rise) state_d = S_HIGH;
        else if (low_gap) begin
          error_d   = 1'b1;
          bit_cnt_d = '0;
          state_d   = S_IDLE;
        end
      end
      S_FWD: begin
        if (low_gap) begin
          latch_d   = 1'b1;
          bit_cnt_d = '0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_WAIT_GAP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      din_meta_q <= 1'b0;
      din_s_q    <= 1'b0;
      din_d_q    <= 1'b0;
      state_q    <= S_WAIT_GAP;
      counter_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
      valid_q    <= 1'b0;
      latch_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      din_meta_q <= din_meta_d;
      din_s_q    <= din_s_d;
      din_d_q    <= din_d_d;
      state_q    <= state_d;
      counter_q  <= counter_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
      valid_q    <= valid_d;
      latch_q    <= latch_d;
      error_q    <= error_d;
    end
  end

  assign bus.dout      = (state_q == S_FWD) & din_s_q;
  assign bus.receiving = (state_q == S_HIGH) | (state_q == S_LOW) | (state_q == S_FWD);
  assign bus.valid     = valid_q;
  assign bus.latch     = latch_q;
  assign bus.error     = error_q;
  assign bus.red       = red_q;
  assign bus.green     = green_q;
  assign bus.blue      = blue_q;
endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: decode, forwarding, gaps, error paths, reset abort.
module tb_ws2812_rx;
  logic clk = 1'b0;
  logic reset;
  ws2812_rx_if bus();

  ws2812_rx dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc = 0, last_fall = 0;
  int n_valid = 0, n_latch = 0, n_error = 0, valid_cyc = 0, latch_cyc = 0;
  int n_multi = 0, n_rgb_glitch = 0, n_dout_bad = 0, n_dout_high = 0;
  logic dout_fwd = 1'b0;
  logic p1 = 1'b0, p2 = 1'b0;
  logic [23:0] prev_rgb = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: pulse counts, pulse times, dout versus the pin delayed 2 clk.
  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin n_valid++; valid_cyc = cyc; end
    if (bus.latch === 1'b1) begin n_latch++; latch_cyc = cyc; end
    if (bus.error === 1'b1) n_error++;
    if (int'(bus.valid === 1'b1) + int'(bus.latch === 1'b1) + int'(bus.error === 1'b1) > 1) n_multi++;
    if (dout_fwd) begin
      if (bus.dout !== p2) n_dout_bad++;
      if (bus.dout === 1'b1) n_dout_high++;
    end else if (bus.dout !== 1'b0) n_dout_bad++;
    p2 = p1;
    p1 = bus.din;
    if (!reset && bus.valid !== 1'b1 && {bus.red, bus.green, bus.blue} !== prev_rgb) n_rgb_glitch++;
    prev_rgb = {bus.red, bus.green, bus.blue};
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 100000", cyc);
    $fatal(1);
  end

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (bus.din === 1'b1 && v == 1'b0) last_fall = cyc;
      bus.din = v;
    end
  endtask

  // Sends the top n bits of w: 1 = 69 high/38 low, 0 = 34 high/73 low.
  task automatic send_bits(input logic [23:0] w, input int n);
    logic [23:0] t;
    t = w;
    for (int i = 0; i < n; i++) begin
      if (t[23]) begin hold(1'b1, 69); hold(1'b0, 38); end
      else       begin hold(1'b1, 34); hold(1'b0, 73); end
      t = t << 1;
    end
  endtask

  task automatic clr_counts();
    n_valid = 0; n_latch = 0; n_error = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.din = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({bus.dout, bus.valid, bus.latch, bus.error, bus.receiving} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {bus.dout, bus.valid, bus.latch, bus.error, bus.receiving}); end
    checks++; if ({bus.red, bus.green, bus.blue} !== 24'h0) begin
      errors++; $display("FAIL reset_rgb: got %h expected 000000", {bus.red, bus.green, bus.blue}); end
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({bus.valid, bus.latch, bus.error, bus.receiving} !== 4'b0) begin
      errors++; $display("FAIL reset_release: got %b expected 0000", {bus.valid, bus.latch, bus.error, bus.receiving}); end
  endtask

  task automatic test_single_word();
    clr_counts();
    hold(1'b0, 4296);
    send_bits(24'h123456, 24);
    hold(1'b0, 4300);
    checks++; if (n_valid !== 1) begin errors++; $display("FAIL single_valid_count: got %0d expected 1", n_valid); end
    checks++; if (valid_cyc !== last_fall + 3) begin
      errors++; $display("FAIL single_valid_latency: got %0d expected %0d", valid_cyc - last_fall, 3); end
    checks++; if ({bus.red, bus.green, bus.blue} !== 24'h341256) begin
      errors++; $display("FAIL single_rgb: got %h expected 341256", {bus.red, bus.green, bus.blue}); end
    checks++; if (n_latch !== 1) begin errors++; $display("FAIL single_latch_count: got %0d expected 1", n_latch); end
    checks++; if (latch_cyc !== last_fall + 4299) begin
      errors++; $display("FAIL single_latch_latency: got %0d expected 4299", latch_cyc - last_fall); end
    checks++; if (n_error !== 0) begin errors++; $display("FAIL single_error: got %0d expected 0", n_error); end
  endtask

  task automatic test_chain();
    clr_counts();
    n_dout_high = 0;
    send_bits(24'hFF00AA, 24);
    dout_fwd = 1'b1;
    send_bits(24'h0F0F0F, 24);
    hold(1'b0, 4300);
    dout_fwd = 1'b0;
    checks++; if ({bus.red, bus.green, bus.blue} !== 24'h00FFAA) begin
      errors++; $display("FAIL chain_rgb: got %h expected 00ffaa", {bus.red, bus.green, bus.blue}); end
    checks++; if (n_valid !== 1) begin errors++; $display("FAIL chain_valid_count: got %0d expected 1", n_valid); end
    checks++; if (n_dout_high !== 1236) begin
      errors++; $display("FAIL chain_dout_high_cycles: got %0d expected 1236", n_dout_high); end
    checks++; if (n_dout_bad !== 0) begin errors++; $display("FAIL chain_dout_shape: got %0d bad cycles expected 0", n_dout_bad); end
    checks++; if (n_latch !== 1 || n_error !== 0) begin
      errors++; $display("FAIL chain_latch_error: got latch=%0d error=%0d expected 1/0", n_latch, n_error); end
  endtask

  task automatic test_short_frame();
    clr_counts();
    send_bits(24'hFFC000, 10);
    hold(1'b0, 4296);
    checks++; if (n_error !== 1) begin errors++; $display("FAIL short_error: got %0d expected 1", n_error); end
    checks++; if (n_valid !== 0 || n_latch !== 0) begin
      errors++; $display("FAIL short_no_pulse: got valid=%0d latch=%0d expected 0/0", n_valid, n_latch); end
    checks++; if ({bus.red, bus.green, bus.blue} !== 24'h00FFAA) begin
      errors++; $display("FAIL short_rgb_kept: got %h expected 00ffaa", {bus.red, bus.green, bus.blue}); end
    clr_counts();
    send_bits(24'hA5C33C, 24);
    hold(1'b0, 4300);
    checks++; if ({bus.red, bus.green, bus.blue} !== 24'hC3A53C || n_valid !== 1) begin
      errors++; $display("FAIL short_next_word: got %h valid=%0d expected c3a53c valid=1", {bus.red, bus.green, bus.blue}, n_valid); end
  endtask

  task automatic test_timeout();
    clr_counts();
    send_bits(24'hA00000, 3);
    hold(1'b1, 200);
    hold(1'b0, 10);
    checks++; if (n_error !== 1) begin errors++; $display("FAIL timeout_error: got %0d expected 1", n_error); end
    checks++; if (bus.receiving !== 1'b0) begin errors++; $display("FAIL timeout_idle: got receiving=%b expected 0", bus.receiving); end
    send_bits(24'h00FF00, 24);
    hold(1'b0, 4300);
    checks++; if (n_valid !== 0 || n_latch !== 0 || n_error !== 1) begin
      errors++; $display("FAIL timeout_ignored: got valid=%0d latch=%0d error=%0d expected 0/0/1", n_valid, n_latch, n_error); end
    send_bits(24'h807F01, 24);
    hold(1'b0, 4300);
    checks++; if ({bus.red, bus.green, bus.blue} !== 24'h7F8001 || n_valid !== 1) begin
      errors++; $display("FAIL timeout_recover: got %h valid=%0d expected 7f8001 valid=1", {bus.red, bus.green, bus.blue}, n_valid); end
  endtask

  task automatic test_glitch_threshold();
    logic [23:0] w;
    clr_counts();
    hold(1'b1, 4);
    hold(1'b0, 20);
    checks++; if (n_error !== 1) begin errors++; $display("FAIL glitch_error: got %0d expected 1", n_error); end
    hold(1'b0, 4300);
    clr_counts();
    // Ones at exactly 52 high, zeros at 51; the final zero uses the 8-cycle minimum.
    w = 24'hB4E196;
    for (int i = 23; i >= 0; i--) begin
      if (w[i])        hold(1'b1, 52);
      else if (i == 0) hold(1'b1, 8);
      else             hold(1'b1, 51);
      hold(1'b0, 55);
    end
    hold(1'b0, 4300);
    checks++; if ({bus.red, bus.green, bus.blue} !== 24'hE1B496) begin
      errors++; $display("FAIL threshold_rgb: got %h expected e1b496", {bus.red, bus.green, bus.blue}); end
    checks++; if (n_valid !== 1 || n_error !== 0 || n_latch !== 1) begin
      errors++; $display("FAIL threshold_pulses: got valid=%0d error=%0d latch=%0d expected 1/0/1", n_valid, n_error, n_latch); end
  endtask

  task automatic test_reset_midframe();
    send_bits(24'h5A5A5A, 11);
    hold(1'b1, 30);
    @(posedge clk); #1 reset = 1'b1;
    bus.din = 1'b0;
    @(negedge clk);
    checks++; if ({bus.dout, bus.valid, bus.latch, bus.error, bus.receiving} !== 5'b0 || {bus.red, bus.green, bus.blue} !== 24'h0) begin
      errors++; $display("FAIL midreset_outputs: got flags=%b rgb=%h expected 00000/000000",
        {bus.dout, bus.valid, bus.latch, bus.error, bus.receiving}, {bus.red, bus.green, bus.blue}); end
    @(posedge clk); #1 reset = 1'b0;
    clr_counts();
    hold(1'b0, 100);
    send_bits(24'h112233, 24);
    hold(1'b0, 4300);
    checks++; if (n_valid !== 0 || n_latch !== 0 || n_error !== 0) begin
      errors++; $display("FAIL midreset_no_pulse: got valid=%0d latch=%0d error=%0d expected 0/0/0", n_valid, n_latch, n_error); end
    checks++; if ({bus.red, bus.green, bus.blue} !== 24'h0) begin
      errors++; $display("FAIL midreset_rgb_zero: got %h expected 000000", {bus.red, bus.green, bus.blue}); end
    send_bits(24'hC0FFEE, 24);
    hold(1'b0, 4300);
    checks++; if ({bus.red, bus.green, bus.blue} !== 24'hFFC0EE || n_valid !== 1 || n_latch !== 1) begin
      errors++; $display("FAIL midreset_first_frame: got %h valid=%0d latch=%0d expected ffc0ee 1/1",
        {bus.red, bus.green, bus.blue}, n_valid, n_latch); end
    checks++; if (n_multi !== 0) begin errors++; $display("FAIL pulse_exclusive: got %0d overlaps expected 0", n_multi); end
    checks++; if (n_rgb_glitch !== 0) begin errors++; $display("FAIL rgb_without_valid: got %0d changes expected 0", n_rgb_glitch); end
    checks++; if (n_dout_bad !== 0) begin errors++; $display("FAIL dout_idle_zero: got %0d bad cycles expected 0", n_dout_bad); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_chain();
    test_short_frame();
    test_timeout();
    test_glitch_threshold();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
